// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, strobe patterns
// and the width of the wait-state counter.
package mem_if_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] STRB_B0 = 4'b0001;
    localparam logic [3:0] STRB_B1 = 4'b0010;
    localparam logic [3:0] STRB_B2 = 4'b0100;
    localparam logic [3:0] STRB_B3 = 4'b1000;
    localparam logic [3:0] STRB_H0 = 4'b0011;
    localparam logic [3:0] STRB_H1 = 4'b1100;
    localparam logic [3:0] STRB_W  = 4'b1111;

endpackage

// File: rtl/dmem_strb_check.sv
// Strobe/address legality check and byte-lane merge of store data into the old word.
module dmem_strb_check
    import mem_if_pkg::*;
(
    input  logic [3:0]  i_wstrb,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    output logic        o_err,
    output logic [31:0] o_merged
);

    logic w_ok;

    always_comb begin
        w_ok = 1'b0;
        case (i_wstrb)
            STRB_B0: w_ok = (i_addr_lo == 2'd0);
            STRB_B1: w_ok = (i_addr_lo == 2'd1);
            STRB_B2: w_ok = (i_addr_lo == 2'd2);
            STRB_B3: w_ok = (i_addr_lo == 2'd3);
            STRB_H0: w_ok = (i_addr_lo == 2'd0);
            STRB_H1: w_ok = (i_addr_lo == 2'd2);
            STRB_W:  w_ok = (i_addr_lo == 2'd0);
            default: w_ok = 1'b0;
        endcase
    end

    assign o_err = ~w_ok;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign o_merged[8*i +: 8] = i_wstrb[i] ? i_wdata[8*i +: 8] : i_old[8*i +: 8];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a core request, waits LATENCY cycles, then performs
// the RAM access and pulses data_ok (with err for misaligned strobe/address pairs).
module dmem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        data_ok,
    output logic        err,
    output logic        stall
);

    localparam logic [LAT_W-1:0] LAT = LAT_W'(LATENCY);

    state_t              r_state;
    logic [LAT_W-1:0]    r_cnt;
    logic                r_wr;
    logic [3:0]          r_wstrb;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_data_ok;
    logic                r_err;
    logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

    logic                w_live;
    logic                w_wr;
    logic [3:0]          w_wstrb;
    logic [ADDR_W+1:0]   w_addr;
    logic [ADDR_W-1:0]   w_idx;
    logic [31:0]         w_old;
    logic [31:0]         w_merged;
    logic                w_err;
    logic                w_to_done;
    logic                w_unused_addr;

    // In IDLE the live request feeds the check so a zero-latency access can register
    // rdata/err on the acceptance edge; otherwise the latched copy is used.
    assign w_live  = (r_state == S_IDLE);
    assign w_wr    = w_live ? wr    : r_wr;
    assign w_wstrb = w_live ? wstrb : r_wstrb;
    assign w_addr  = w_live ? addr[ADDR_W+1:0] : r_addr;
    assign w_idx   = w_addr[ADDR_W+1:2];
    assign w_old   = r_mem[w_idx];

    assign w_unused_addr = ^addr[31:ADDR_W+2];

    dmem_strb_check u_check (
        .i_wstrb   (w_wstrb),
        .i_addr_lo (w_addr[1:0]),
        .i_old     (w_old),
        .i_wdata   (r_wdata),
        .o_err     (w_err),
        .o_merged  (w_merged)
    );

    assign w_to_done = (r_state == S_IDLE && req && LAT == '0)
                     || (r_state == S_WAIT && r_cnt == LAT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_data_ok <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_data_ok <= w_to_done;
            r_err     <= w_to_done & w_err;
            if (w_to_done && !w_wr && !w_err)
                r_rdata <= w_old;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_wr    <= wr;
                        r_wstrb <= wstrb;
                        r_addr  <= addr[ADDR_W+1:0];
                        r_wdata <= wdata;
                        r_cnt   <= LAT;
                        r_state <= (LAT == '0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == LAT_W'(1))
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // In DONE the check sees the latched request, so w_idx/w_err/w_merged describe it.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_DONE && r_wr && !w_err)
            r_mem[w_idx] <= w_merged;
    end

    assign rdata   = r_rdata;
    assign data_ok = r_data_ok;
    assign err     = r_err;
    assign stall   = req & ~r_data_ok;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table-driven accesses on a LATENCY=2 instance with a
// scoreboard queue, plus reset and zero-latency back-to-back sequences.
module tb_dmem_responder;

    typedef struct {
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_err;
        logic [31:0] e_rdata;
    } tv_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, req, wr;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata, rdata;
    logic        data_ok, err, stall;

    logic        rst_b, req_b, wr_b;
    logic [3:0]  wstrb_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic        data_ok_b, err_b, stall_b;

    int   n_cmp = 0;
    int   n_bad = 0;
    tv_t  tv[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
        .wdata(wdata), .rdata(rdata), .data_ok(data_ok), .err(err), .stall(stall)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst_b), .req(req_b), .wr(wr_b), .wstrb(wstrb_b), .addr(addr_b),
        .wdata(wdata_b), .rdata(rdata_b), .data_ok(data_ok_b), .err(err_b), .stall(stall_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One access on the LATENCY=2 instance; request fields are scrambled after
    // acceptance to show the latched copy is what gets used.
    task automatic access(input int id, input tv_t v);
        exp_t e;
        int   lat;
        int   st;
        logic seen;
        logic err_early;
        req = 1'b1; wr = v.wr; wstrb = v.strb; addr = v.addr; wdata = v.wdata;
        sb.push_back('{err: v.e_err, rdata: v.e_rdata});
        lat = 0; st = 0; seen = 1'b0; err_early = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (data_ok) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                if (stall) st++;
                if (err) err_early = 1'b1;
                if (i == 1) begin
                    wr = ~v.wr; wstrb = ~v.strb; addr = ~v.addr; wdata = ~v.wdata;
                end
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout vec %0d: no data_ok within 40 cycles", id);
        end else begin
            chk($sformatf("latency v%0d", id), lat, 3);
            chk($sformatf("stall_cycles v%0d", id), st, 3);
            chk($sformatf("stall_at_ok v%0d", id), {31'b0, stall}, 0);
            chk($sformatf("err_before_ok v%0d", id), {31'b0, err_early}, 0);
            chk($sformatf("err v%0d", id), {31'b0, err}, {31'b0, e.err});
            chk($sformatf("rdata v%0d", id), rdata, e.rdata);
        end
        @(posedge clk); #1;
        req = 1'b0; wr = 1'b0;
    endtask

    initial begin
        logic         any_ok;
        exp_t         e;
        rst = 1'b1; req = 1'b1; wr = 1'b0; wstrb = 4'hF; addr = 32'h40; wdata = '0;
        rst_b = 1'b1; req_b = 1'b0; wr_b = 1'b0; wstrb_b = 4'hF; addr_b = '0; wdata_b = '0;

        // Reset values; req held high through reset must not be accepted.
        @(posedge clk); @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_data_ok", {31'b0, data_ok}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_stall_follows_req", {31'b0, stall}, 1);
        @(posedge clk); #1;
        rst = 1'b0; rst_b = 1'b0; req = 1'b0;
        any_ok = 1'b0;
        repeat (6) begin @(negedge clk); if (data_ok) any_ok = 1'b1; end
        chk("reset_wins_no_ok", {31'b0, any_ok}, 0);
        @(posedge clk); #1;

        tv.push_back('{1'b1, 4'b1111, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000});
        tv.push_back('{1'b0, 4'b1111, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF});
        tv.push_back('{1'b1, 4'b1111, 32'h0000_0080, 32'h1122_3344, 1'b0, 32'hDEAD_BEEF});
        tv.push_back('{1'b1, 4'b0010, 32'h0000_0081, 32'h0000_AA00, 1'b0, 32'hDEAD_BEEF});
        tv.push_back('{1'b1, 4'b1100, 32'h0000_0082, 32'h5566_0000, 1'b0, 32'hDEAD_BEEF});
        tv.push_back('{1'b0, 4'b1111, 32'h0000_0080, 32'h0,         1'b0, 32'h5566_AA44});
        tv.push_back('{1'b1, 4'b1111, 32'h0000_0042, 32'hFFFF_FFFF, 1'b1, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b0011, 32'h0000_0041, 32'h0,         1'b1, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b1111, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF});
        tv.push_back('{1'b1, 4'b0010, 32'h0000_0080, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF});
        tv.push_back('{1'b0, 4'b1111, 32'h0000_0080, 32'h0,         1'b0, 32'h5566_AA44});
        tv.push_back('{1'b1, 4'b1111, 32'h0000_1000, 32'hA5A5_5A5A, 1'b0, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b1111, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_5A5A});
        tv.push_back('{1'b0, 4'b1111, 32'h0000_1040, 32'h0,         1'b0, 32'hDEAD_BEEF});
        tv.push_back('{1'b0, 4'b0010, 32'h0000_0081, 32'h0,         1'b0, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b1000, 32'h0000_0043, 32'h0,         1'b0, 32'hDEAD_BEEF});
        tv.push_back('{1'b0, 4'b0100, 32'h0000_0082, 32'h0,         1'b0, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b0001, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF});
        tv.push_back('{1'b0, 4'b1100, 32'h0000_0082, 32'h0,         1'b0, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b0001, 32'h0000_0041, 32'h0,         1'b1, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b0000, 32'h0000_0040, 32'h0,         1'b1, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b0110, 32'h0000_0041, 32'h0,         1'b1, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b0011, 32'h0000_0042, 32'h0,         1'b1, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b1100, 32'h0000_0040, 32'h0,         1'b1, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b1111, 32'h0000_0041, 32'h0,         1'b1, 32'h5566_AA44});
        tv.push_back('{1'b0, 4'b0001, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_5A5A});
        tv.push_back('{1'b1, 4'b1111, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 32'hA5A5_5A5A});
        tv.push_back('{1'b0, 4'b1111, 32'h0000_0010, 32'h0,         1'b0, 32'hCAFE_F00D});

        foreach (tv[i]) access(i, tv[i]);

        // Reset one cycle after acceptance of a store: abandoned, never written.
        req = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'h10; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk("midwait_rst_rdata", rdata, 0);
        any_ok = data_ok;
        repeat (5) begin @(negedge clk); if (data_ok) any_ok = 1'b1; end
        chk("midwait_no_ok", {31'b0, any_ok}, 0);
        @(posedge clk); #1;
        access(100, '{1'b0, 4'b1111, 32'h0000_0010, 32'h0, 1'b0, 32'hCAFE_F00D});

        // LATENCY=0: one store, then req held for four loads.
        req_b = 1'b1; wr_b = 1'b1; wstrb_b = 4'hF; addr_b = 32'h20; wdata_b = 32'h0BAD_CAFE;
        @(negedge clk);
        chk("l0_store_ok_c0", {31'b0, data_ok_b}, 0);
        chk("l0_store_stall_c0", {31'b0, stall_b}, 1);
        @(negedge clk);
        chk("l0_store_ok_c1", {31'b0, data_ok_b}, 1);
        chk("l0_store_err", {31'b0, err_b}, 0);
        @(posedge clk); #1;
        req_b = 1'b0; wr_b = 1'b0;
        @(posedge clk); #1;
        req_b = 1'b1;
        repeat (4) sb.push_back('{err: 1'b0, rdata: 32'h0BAD_CAFE});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("l0_ok c%0d", i), {31'b0, data_ok_b}, {31'b0, (i % 2 == 1)});
            chk($sformatf("l0_stall c%0d", i), {31'b0, stall_b}, {31'b0, (i % 2 == 0)});
            if (data_ok_b) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL l0_extra_ok c%0d: data_ok with empty scoreboard", i);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("l0_rdata c%0d", i), rdata_b, e.rdata);
                    chk($sformatf("l0_err c%0d", i), {31'b0, err_b}, {31'b0, e.err});
                end
            end
        end
        @(posedge clk); #1;
        req_b = 1'b0;
        chk("l0_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the CPU data-memory port: it answers the load/store requests the pipelined MIPS datapath issues in its memory stage. It owns a word-addressed on-chip RAM with byte-lane writes and a programmable number of wait states. It drives a stall back to the core while an access is outstanding and flags misaligned strobe/address combinations as errors.

## Interface
Parameters:
- `ADDR_W`, 10: log2 of RAM depth in 32-bit words.
- `LATENCY`, 2: wait cycles inserted between acceptance and completion; legal range 0..15.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  1  request valid; the core holds it and all request fields stable until `data_ok`.
- `wr`  in  1  1 = store, 0 = load.
- `wstrb`  in  4  byte-lane enables; bit i is byte lane i (little-endian). For loads it gives the access size.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, already lane-aligned.
- `rdata`  out  32  load result, full word; registered.
- `data_ok`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `data_ok`: misaligned access, no RAM effect.
- `stall`  out  1  combinational `req & ~data_ok`; feeds the pipeline stall.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - With `req`=1: latch `wr`, `wstrb`, `addr`, `wdata`; load the countdown with `LATENCY`.
  - Go to WAIT if `LATENCY`>0, else DONE.
  - With `req`=0: stay in IDLE.
- **WAIT**
  - Decrement the counter each cycle.
  - Go to DONE in the cycle the counter goes 1→0.
- **DONE**
  - Perform the access using the latched request and assert `data_ok` for exactly this cycle.
  - Return to IDLE unconditionally.
- Legal strobe/address pairs; anything else sets `err`=1:
  - byte: one-hot `wstrb` whose set bit equals `addr[1:0]`;
  - halfword: `wstrb`=0011 with `addr[1:0]`=00, or 1100 with `addr[1:0]`=10;
  - word: `wstrb`=1111 with `addr[1:0]`=00;
  - `wstrb`=0000 is illegal.
- Store, legal: write only the enabled lanes of `mem[addr[ADDR_W+1:2]]`. Lanes not enabled keep their old value.
- Load, legal: `rdata` ← the full word at the index. `wstrb` does not mask it; the core extracts and extends.
- Error access: no RAM write; `rdata` is unchanged; `data_ok`=1 and `err`=1 together.
- Address wrap: address bits above `ADDR_W+1` are ignored, so the address aliases modulo the RAM size.
- `rdata` holds its value until the next successful load. `err` is 0 whenever `data_ok` is 0.
- Request fields changing while an access is outstanding has no effect, because the latched copy is used.

## Timing
- Request accepted in cycle T completes (`data_ok`) in cycle T+1+`LATENCY`.
- The next request can be accepted no earlier than T+2+`LATENCY`, i.e. one dead IDLE cycle after DONE. Throughput is one access per `LATENCY`+2 cycles.
- `stall` is high from T through T+`LATENCY` and low in the `data_ok` cycle, so the core advances on the same edge that registers `rdata`.
- `rdata` is valid in the `data_ok` cycle and remains valid afterwards.
- Reset values: state=IDLE, counter=0, `rdata`=0, `data_ok`=0, `err`=0. `stall` follows `req`.
- Reset mid-operation: the outstanding access is abandoned, a pending store is not written, and no `data_ok` is produced. RAM contents are not cleared by reset.
- Reset together with `req`: reset wins and the request is not accepted in that cycle.

## Structure
- Shared package (`mem_if_pkg`) holds:
  - FSM state encodings (2-bit);
  - strobe constants: `STRB_B0`..`STRB_B3`, `STRB_H0`, `STRB_H1`, `STRB_W`;
  - the `LATENCY` width constant (4 bits).
- One sub-module, `dmem_strb_check`: combinational legality check plus byte-lane merge.
  - Inputs: `wstrb`, `addr[1:0]`, old word, `wdata`.
  - Outputs: `err`, merged word.
- RAM is an inferred array of 2^`ADDR_W` × 32 with no reset, written only in DONE.

## Test plan
- **Word store then load, `LATENCY`=2:** store 0xDEADBEEF at 0x40 with `wstrb`=1111, then load 0x40. Each access gets `data_ok` at T+3, `rdata`=0xDEADBEEF, and `stall` is high for 3 cycles per access.
- **Byte and halfword merge:** preload 0x11223344 at 0x80. Store byte 0xAA at 0x81 (`wstrb`=0010), then halfword 0x5566 at 0x82 (`wstrb`=1100). A load of 0x80 returns 0x5566AA44.
- **Misaligned:** a word store to 0x42, then a halfword load with `wstrb`=0011 at 0x41. Both give `data_ok`=1, `err`=1, the RAM is unchanged and `rdata` is unchanged.
- **`LATENCY`=0 back-to-back:** hold `req` high for 4 loads. `data_ok` pulses every 2 cycles, and `stall` is low exactly in those cycles.
- **Reset mid-WAIT:** start a store of 0x12345678 to 0x10 and assert `rst` one cycle after acceptance. There is no `data_ok`, a later load of 0x10 returns the old value, and `rdata`=0 immediately after reset.
- **Address wrap, `ADDR_W`=10:** a store to 0x1000 followed by a load from 0x0 returns the stored word.
